// File: rtl/audio_level_meter.sv
// Stereo level meter for the PCM1801 receiver: re-times L/R words into clk, then tracks
// per-channel peak with hold and decay, a log-scale thermometer bar and a held clip flag.
module audio_level_meter #(
    parameter int W            = 16,
    parameter int BAR          = 8,
    parameter int HOLD_SAMPLES = 4096,
    parameter int DECAY_SHIFT  = 6,
    parameter int CLIP_LEVEL   = 32000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           lrck,
    input  logic [W-1:0]   left,
    input  logic [W-1:0]   right,
    output logic [W-1:0]   left_sample,
    output logic [W-1:0]   right_sample,
    output logic           sample_valid,
    output logic [W-2:0]   left_peak,
    output logic [W-2:0]   right_peak,
    output logic [BAR-1:0] left_bar,
    output logic [BAR-1:0] right_bar,
    output logic           left_clip,
    output logic           right_clip
);

    localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES - 1);
    localparam logic [W-1:0]  CLIP_THR  = W'(CLIP_LEVEL);

    logic           lrck_s1, lrck_s2, lrck_prev;
    logic [1:0]     arm_cnt;
    logic           armed, lrck_fall, lrck_rise;
    logic           have_left;
    logic           upd;
    logic [1:0][W-2:0]   mag, peak;
    logic [1:0][HW-1:0]  hold_cnt, clip_cnt;
    logic [1:0]          clip;
    logic [1:0][BAR-1:0] bar;

    function automatic logic [W-2:0] abs_sat(input logic [W-1:0] s);
        logic [W-1:0] n;
        n = -s;
        if (!s[W-1])
            return s[W-2:0];
        else if (n[W-1])
            return '1;
        else
            return n[W-2:0];
    endfunction

    function automatic logic [W-2:0] decay(input logic [W-2:0] p);
        logic [W-2:0] step;
        step = (p >> DECAY_SHIFT) + {{(W-2){1'b0}}, 1'b1};
        return (p > step) ? p - step : '0;
    endfunction

    function automatic logic [BAR-1:0] thermo(input logic [W-2:0] p);
        logic [BAR-1:0] b;
        b = '0;
        for (int i = 0; i < BAR; i++)
            b[i] = ({1'b0, p} >= (W'(1) << (W - 1 - BAR + i)));
        return b;
    endfunction

    // Edge detect stays disarmed for 3 cycles after reset so the sync chain settles first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_s1   <= 1'b0;
            lrck_s2   <= 1'b0;
            lrck_prev <= 1'b0;
            arm_cnt   <= 2'd3;
        end else begin
            lrck_s1   <= lrck;
            lrck_s2   <= lrck_s1;
            lrck_prev <= lrck_s2;
            if (arm_cnt != 2'd0)
                arm_cnt <= arm_cnt - 2'd1;
        end
    end

    assign armed     = (arm_cnt == 2'd0);
    assign lrck_fall = armed &  lrck_prev & ~lrck_s2;
    assign lrck_rise = armed & ~lrck_prev &  lrck_s2;

    // A pair is only published once a fall (left) has been seen before the rise (right).
    always_ff @(posedge clk) begin
        if (rst) begin
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            have_left    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (lrck_fall) begin
                left_sample <= left;
                have_left   <= 1'b1;
            end
            if (lrck_rise && have_left) begin
                right_sample <= right;
                sample_valid <= 1'b1;
                have_left    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd      <= 1'b0;
            mag      <= '0;
            peak     <= '0;
            hold_cnt <= '0;
            clip_cnt <= '0;
            clip     <= '0;
            bar      <= '0;
        end else begin
            upd <= sample_valid;
            if (sample_valid) begin
                mag[0] <= abs_sat(left_sample);
                mag[1] <= abs_sat(right_sample);
            end
            if (upd) begin
                for (int c = 0; c < 2; c++) begin
                    if (mag[c] > peak[c]) begin
                        peak[c]     <= mag[c];
                        hold_cnt[c] <= HOLD_LOAD;
                    end else if (hold_cnt[c] != '0) begin
                        hold_cnt[c] <= hold_cnt[c] - HW'(1);
                    end else begin
                        peak[c] <= decay(peak[c]);
                    end
                    if ({1'b0, mag[c]} >= CLIP_THR) begin
                        clip[c]     <= 1'b1;
                        clip_cnt[c] <= HOLD_LOAD;
                    end else if (clip_cnt[c] != '0) begin
                        clip_cnt[c] <= clip_cnt[c] - HW'(1);
                    end else begin
                        clip[c] <= 1'b0;
                    end
                end
            end
            for (int c = 0; c < 2; c++)
                bar[c] <= thermo(peak[c]);
        end
    end

    assign left_peak  = peak[0];
    assign right_peak = peak[1];
    assign left_bar   = bar[0];
    assign right_bar  = bar[1];
    assign left_clip  = clip[0];
    assign right_clip = clip[1];

endmodule
